// File: rtl/uart_pkg.sv
// Shared encodings for the UART transmit path: parity codes, frame states
// and the bit counter width rule.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_STOP2  = 3'd5
  } state_e;

  // Per-frame configuration, frozen at frame launch.
  typedef struct packed {
    logic [1:0] parity;
    logic       stop2;
  } frame_cfg_t;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_hold.sv
// One-entry valid/ready holding register feeding the frame serialiser.
module uart_tx_hold #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  input  logic         unload,
  output logic         full,
  output logic [W-1:0] data
);

  // s_ready is kept as its own flop (always !full) so the source sees a clean
  // registered handshake; unload only happens when full, so load/unload never
  // collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      full    <= 1'b0;
      s_ready <= 1'b1;
    end else if (s_valid && s_ready) begin
      full    <= 1'b1;
      s_ready <= 1'b0;
      data    <= s_data;
    end else if (unload) begin
      full    <= 1'b0;
      s_ready <= 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// Tick-paced UART frame serialiser: start, DATA_BITS LSB first, optional
// parity, 1 or 2 stop bits; gapless back-to-back via the holding register.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int   DATA_BITS  = 8,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_BITS-1:0] s_data,
  input  logic [1:0]           cfg_parity,
  input  logic                 cfg_stop2,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int CW = cnt_w(DATA_BITS);

  state_e               state, state_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [CW-1:0]        cnt, cnt_n;
  frame_cfg_t           cfg_q, cfg_n;
  logic                 par_bit, par_bit_n;
  logic                 tx_n, done_n, unload, final_stop, par_en;
  logic                 hold_full;
  logic [DATA_BITS-1:0] hold_data;

  uart_tx_hold #(.W(DATA_BITS)) u_hold (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .unload  (unload),
    .full    (hold_full),
    .data    (hold_data)
  );

  assign busy   = (state != ST_IDLE);
  assign par_en = (cfg_q.parity == PAR_EVEN) || (cfg_q.parity == PAR_ODD);

  always_comb begin
    state_n    = state;
    shift_n    = shift;
    cnt_n      = cnt;
    cfg_n      = cfg_q;
    par_bit_n  = par_bit;
    unload     = 1'b0;
    done_n     = 1'b0;
    final_stop = 1'b0;
    if (tick) begin
      case (state)
        ST_START: begin
          state_n = ST_DATA;
          cnt_n   = '0;
        end
        ST_DATA: begin
          shift_n = shift >> 1;
          cnt_n   = cnt + 1'b1;
          if (cnt == CW'(DATA_BITS - 1)) state_n = par_en ? ST_PARITY : ST_STOP;
        end
        ST_PARITY: state_n = ST_STOP;
        ST_STOP: begin
          if (cfg_q.stop2) state_n = ST_STOP2;
          else             final_stop = 1'b1;
        end
        ST_STOP2: final_stop = 1'b1;
        default: ;
      endcase
      if (final_stop) begin
        done_n  = 1'b1;
        state_n = ST_IDLE;
      end
      // Launch from IDLE or straight off the final stop tick (gapless).
      if (hold_full && (state == ST_IDLE || final_stop)) begin
        unload    = 1'b1;
        shift_n   = hold_data;
        cfg_n     = '{parity: cfg_parity, stop2: cfg_stop2};
        par_bit_n = (cfg_parity == PAR_ODD) ? ~^hold_data : ^hold_data;
        state_n   = ST_START;
      end
    end
    // Line level is derived from the next state so tx is a clean flop output.
    case (state_n)
      ST_START:  tx_n = ~IDLE_LEVEL;
      ST_DATA:   tx_n = shift_n[0];
      ST_PARITY: tx_n = par_bit_n;
      default:   tx_n = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      shift   <= '0;
      cnt     <= '0;
      cfg_q   <= '0;
      par_bit <= 1'b0;
      tx      <= IDLE_LEVEL;
      tx_done <= 1'b0;
    end else begin
      state   <= state_n;
      shift   <= shift_n;
      cnt     <= cnt_n;
      cfg_q   <= cfg_n;
      par_bit <= par_bit_n;
      tx      <= tx_n;
      tx_done <= done_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: per-tick-period line capture compared against
// frame bit strings from a table and from an arithmetic frame model.
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rst, tick, s_valid, s_ready, cfg_stop2, tx, busy, tx_done;
  logic [7:0] s_data;
  logic [1:0] cfg_parity;

  uart_tx_frame #(.DATA_BITS(8), .IDLE_LEVEL(1'b1)) dut (
    .clk(clk), .rst(rst), .tick(tick), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .tx(tx), .busy(busy), .tx_done(tx_done)
  );

  initial forever #5 clk = ~clk;

  typedef struct { logic tx; logic busy; logic done; } rec_t;
  typedef struct { logic [7:0] data; logic [1:0] par; logic stop2; int len; logic [15:0] bits; } vec_t;

  rec_t        cap_q[$];
  bit          rec_en = 1'b0;
  int          tests = 0, fails = 0, acc_cnt = 0;
  logic [15:0] exp_b[4];
  int          exp_l[4];
  logic        r_tx, r_busy, r_done;

  // Tick every 16 clk; one record per tick period (line sampled mid-period,
  // tx_done OR-ed across the period).
  initial begin
    tick = 1'b0;
    forever begin
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0; r_done = tx_done;
      for (int i = 0; i < 14; i++) begin
        @(negedge clk);
        r_done = r_done | tx_done;
        if (i == 6) begin r_tx = tx; r_busy = busy; end
      end
      if (rec_en) cap_q.push_back('{r_tx, r_busy, r_done});
    end
  end

  always @(posedge clk) if (!rst && s_valid && s_ready) acc_cnt++;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Frame bits from the line rules: start 0, data LSB first, parity by
  // count of ones, then stop bits.
  function automatic void model(input logic [7:0] d, input logic [1:0] par, input logic st2,
                                output logic [15:0] b, output int len);
    int ones;
    b = '0; len = 1;
    for (int i = 0; i < 8; i++) begin b[len] = d[i]; len++; end
    ones = $countones(d);
    if (par == 2'd1) begin b[len] = (ones % 2 == 1); len++; end
    if (par == 2'd2) begin b[len] = (ones % 2 == 0); len++; end
    b[len] = 1'b1; len++;
    if (st2) begin b[len] = 1'b1; len++; end
  endfunction

  function automatic rec_t at(input int i);
    if (i < cap_q.size()) return cap_q[i];
    return '{1'bx, 1'bx, 1'bx};
  endfunction

  task automatic push(input logic [7:0] w);
    int n = 0;
    s_valid = 1'b1; s_data = w;
    while (!s_ready && n < 1000) begin @(negedge clk); n++; end
    chk("push_timeout", 16'(n >= 1000), 16'd0);
    @(negedge clk);
    chk("ready_low_after_accept", 16'(s_ready), 16'd0);
    s_valid = 1'b0;
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!busy && n < 100) begin @(negedge clk); n++; end
    chk("busy_timeout", 16'(n >= 100), 16'd0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || !s_ready) && n < 2000) begin @(negedge clk); n++; end
    chk("idle_timeout", 16'(n >= 2000), 16'd0);
  endtask

  task automatic start_rec();
    cap_q.delete(); rec_en = 1'b1;
  endtask

  task automatic end_rec();
    wait_idle();
    repeat (40) @(negedge clk);
    rec_en = 1'b0;
  endtask

  // Locate the first busy period and walk the expected frames from there.
  task automatic analyze(input int nf, input string tag);
    int s = -1, pos, run = 0, dcnt = 0;
    logic [15:0] got;
    for (int i = 0; i < cap_q.size(); i++) if (cap_q[i].busy === 1'b1 && s < 0) s = i;
    chk({tag, ".frame_seen"}, 16'(s >= 0), 16'd1);
    if (s < 0) return;
    pos = s;
    for (int f = 0; f < nf; f++) begin
      got = '0;
      for (int k = 0; k < exp_l[f]; k++) got[k] = at(pos + k).tx;
      chk($sformatf("%s.f%0d.bits", tag, f), got, exp_b[f]);
      pos += exp_l[f];
      chk($sformatf("%s.f%0d.done", tag, f), 16'(at(pos).done), 16'd1);
    end
    for (int i = s; i < cap_q.size() && cap_q[i].busy === 1'b1; i++) run++;
    chk({tag, ".busy_periods"}, 16'(run), 16'(pos - s));
    foreach (cap_q[i]) if (cap_q[i].done === 1'b1) dcnt++;
    chk({tag, ".done_count"}, 16'(dcnt), 16'(nf));
    chk({tag, ".idle_after"}, {14'd0, at(pos).tx, at(pos).busy}, 16'b10);
  endtask

  vec_t tbl[7];

  initial begin
    int a0, dcnt, bcnt;
    logic [7:0] d1, d2;
    logic [1:0] p;
    logic st;

    tbl[0] = '{8'hA5, 2'd0, 1'b0, 10, 16'h034A};
    tbl[1] = '{8'hA5, 2'd1, 1'b0, 11, 16'h054A};
    tbl[2] = '{8'hA5, 2'd2, 1'b0, 11, 16'h074A};
    tbl[3] = '{8'h3C, 2'd0, 1'b1, 11, 16'h0678};
    tbl[4] = '{8'h3C, 2'd3, 1'b0, 10, 16'h0278};
    tbl[5] = '{8'hFF, 2'd2, 1'b1, 12, 16'h0FFE};
    tbl[6] = '{8'h00, 2'd1, 1'b0, 11, 16'h0400};

    rst = 1'b1; s_valid = 1'b0; s_data = '0; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset.tx", 16'(tx), 16'd1);
    chk("reset.busy", 16'(busy), 16'd0);
    chk("reset.tx_done", 16'(tx_done), 16'd0);
    chk("reset.s_ready", 16'(s_ready), 16'd1);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Single frames from the table
    for (int v = 0; v < 7; v++) begin
      wait_idle();
      cfg_parity = tbl[v].par; cfg_stop2 = tbl[v].stop2;
      start_rec();
      push(tbl[v].data);
      end_rec();
      exp_b[0] = tbl[v].bits; exp_l[0] = tbl[v].len;
      analyze(1, $sformatf("tbl%0d", v));
    end

    // Back-to-back with s_valid held: three contiguous 10-tick frames
    wait_idle();
    cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    a0 = acc_cnt;
    start_rec();
    push(8'h55); push(8'h0F); push(8'hF0);
    end_rec();
    chk("b2b.accepts", 16'(acc_cnt - a0), 16'd3);
    model(8'h55, 2'd0, 1'b0, exp_b[0], exp_l[0]);
    model(8'h0F, 2'd0, 1'b0, exp_b[1], exp_l[1]);
    model(8'hF0, 2'd0, 1'b0, exp_b[2], exp_l[2]);
    analyze(3, "b2b");

    // Parity switched to odd while the first frame is on the line
    wait_idle();
    cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    start_rec();
    push(8'h5A);
    wait_busy();
    cfg_parity = 2'd2;
    push(8'hC3);
    end_rec();
    model(8'h5A, 2'd0, 1'b0, exp_b[0], exp_l[0]);
    model(8'hC3, 2'd2, 1'b0, exp_b[1], exp_l[1]);
    analyze(2, "cfg_mid");

    // Randomised back-to-back pairs
    for (int r = 0; r < 6; r++) begin
      d1 = 8'($urandom); d2 = 8'($urandom);
      p = 2'($urandom_range(0, 3)); st = 1'($urandom_range(0, 1));
      wait_idle();
      cfg_parity = p; cfg_stop2 = st;
      start_rec();
      push(d1); push(d2);
      end_rec();
      model(d1, p, st, exp_b[0], exp_l[0]);
      model(d2, p, st, exp_b[1], exp_l[1]);
      analyze(2, $sformatf("rnd%0d", r));
    end

    // Reset during DATA of 0x81 with a second word held
    wait_idle();
    cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    push(8'h81);
    wait_busy();
    push(8'hE7);
    repeat (3 * 16) @(negedge clk);
    chk("rst_mid.busy_before", 16'(busy), 16'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid.tx", 16'(tx), 16'd1);
    chk("rst_mid.busy", 16'(busy), 16'd0);
    chk("rst_mid.s_ready", 16'(s_ready), 16'd1);
    chk("rst_mid.tx_done", 16'(tx_done), 16'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    start_rec();
    repeat (25 * 16) @(negedge clk);
    rec_en = 1'b0;
    dcnt = 0; bcnt = 0;
    foreach (cap_q[i]) begin
      if (cap_q[i].done === 1'b1) dcnt++;
      if (cap_q[i].busy !== 1'b0) bcnt++;
    end
    chk("rst_mid.no_done", 16'(dcnt), 16'd0);
    chk("rst_mid.held_dropped", 16'(bcnt), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
